// File: rtl/sys_pkg.sv
// Shared definitions for the boot loader: loader FSM states and the SRAM
// geometry that the loader parameters default to.
package sys_pkg;

  localparam int SRAM_DATA_W = 32'd45;
  localparam int SRAM_DEPTH  = 32'd512;
  localparam int SRAM_COLS   = 32'd4;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    FILL  = 3'd2,
    HOLD  = 3'd3,
    RUN   = 3'd4,
    ERROR = 3'd5
  } boot_state_e;

endpackage

// File: rtl/sram_boot_loader_if.sv
// Boot stream (valid/ready) plus SRAM write port seen by the loader.
// The slave modport is the loader side; master is the source/SRAM side.
interface sram_boot_loader_if
  import sys_pkg::*;
#(
  parameter int DATA_W = SRAM_DATA_W,
  parameter int DEPTH  = SRAM_DEPTH,
  parameter int COLS   = SRAM_COLS
);

  localparam int ROW_W = $clog2(DEPTH / COLS);
  localparam int COL_W = $clog2(COLS);

  logic              s_valid;
  logic              s_ready;
  logic [DATA_W-1:0] s_data;
  logic              s_last;
  logic              sram_we;
  logic [ROW_W-1:0]  sram_row;
  logic [COL_W-1:0]  sram_col;
  logic [DATA_W-1:0] sram_wdata;

  modport master (
    output s_valid, s_data, s_last,
    input  s_ready, sram_we, sram_row, sram_col, sram_wdata
  );

  modport slave (
    input  s_valid, s_data, s_last,
    output s_ready, sram_we, sram_row, sram_col, sram_wdata
  );

endinterface

// File: rtl/boot_addr_gen.sv
// Linear SRAM address counter shared by the load and fill phases, with the
// row/column split and the terminal-count flags the loader FSM needs.
module boot_addr_gen
  import sys_pkg::*;
#(
  parameter int DEPTH = SRAM_DEPTH,
  parameter int COLS  = SRAM_COLS,
  localparam int ADDR_W = $clog2(DEPTH),
  localparam int ROW_W  = $clog2(DEPTH / COLS),
  localparam int COL_W  = $clog2(COLS)
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              clr_s,
  input  logic              inc_s,
  output logic [ADDR_W:0]   addr_r,
  output logic [ROW_W-1:0]  row_s,
  output logic [COL_W-1:0]  col_s,
  output logic              full_s,
  output logic              last_s
);

  // One extra bit so the counter can sit at DEPTH when the SRAM is full.
  localparam logic [ADDR_W:0] ADDR_ONE  = (ADDR_W + 1)'(32'd1);
  localparam logic [ADDR_W:0] ADDR_FULL = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W:0] ADDR_LAST = (ADDR_W + 1)'(DEPTH - 32'd1);

  // Address counter: cleared at the start of a load, stepped per write.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      addr_r <= '0;
    end else if (clr_s) begin
      addr_r <= '0;
    end else if (inc_s) begin
      addr_r <= addr_r + ADDR_ONE;
    end else begin
      addr_r <= addr_r;
    end
  end

  assign row_s  = addr_r[ADDR_W-1:COL_W];
  assign col_s  = addr_r[COL_W-1:0];
  assign full_s = (addr_r == ADDR_FULL);
  assign last_s = (addr_r == ADDR_LAST);

endmodule

// File: rtl/sram_boot_loader.sv
// Front-door firmware loader: streams words into the SRAM, verifies the XOR
// checksum, optionally zero-fills the remainder, then releases the CPU.
module sram_boot_loader
  import sys_pkg::*;
#(
  parameter int DATA_W      = SRAM_DATA_W,
  parameter int DEPTH       = SRAM_DEPTH,
  parameter int COLS        = SRAM_COLS,
  parameter int HOLD_CYCLES = 32'd16,
  parameter int ZERO_FILL   = 32'd1
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     start,
  sram_boot_loader_if.slave        bus,
  output logic                     cpu_resetn,
  output logic                     done,
  output logic                     error,
  output logic [$clog2(DEPTH):0]   words_loaded
);

  localparam int ADDR_W = $clog2(DEPTH);
  localparam int ROW_W  = $clog2(DEPTH / COLS);
  localparam int COL_W  = $clog2(COLS);
  localparam int HOLD_W = $clog2(HOLD_CYCLES + 32'd1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 32'd1);
  localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(32'd1);

  boot_state_e       state_r;
  boot_state_e       state_nx_s;
  logic [DATA_W-1:0] checksum_r;
  logic [ADDR_W:0]   words_r;
  logic [HOLD_W-1:0] hold_cnt_r;
  logic              s_ready_r;
  logic              we_r;
  logic [ROW_W-1:0]  row_r;
  logic [COL_W-1:0]  col_r;
  logic [DATA_W-1:0] wdata_r;
  logic              cpu_resetn_r;
  logic              done_r;
  logic              error_r;

  logic              accept_s;
  logic              addr_clr_s;
  logic              wr_s;
  logic              last_ok_s;
  logic [ADDR_W:0]   addr_s;
  logic [ROW_W-1:0]  row_s;
  logic [COL_W-1:0]  col_s;
  logic              full_s;
  logic              last_s;

  boot_addr_gen #(
    .DEPTH (DEPTH),
    .COLS  (COLS)
  ) u_addr (
    .clk    (clk),
    .resetn (resetn),
    .clr_s  (addr_clr_s),
    .inc_s  (wr_s),
    .addr_r (addr_s),
    .row_s  (row_s),
    .col_s  (col_s),
    .full_s (full_s),
    .last_s (last_s)
  );

  // s_ready_r is high exactly while in LOAD, so it doubles as the state qualifier.
  assign accept_s = bus.s_valid & s_ready_r;

  // Next-state decode plus the per-cycle write and counter controls.
  always_comb begin
    state_nx_s = state_r;
    addr_clr_s = 1'b0;
    wr_s       = 1'b0;
    last_ok_s  = 1'b0;
    case (state_r)
      IDLE, RUN, ERROR: begin
        if (start) begin
          state_nx_s = LOAD;
          addr_clr_s = 1'b1;
        end else begin
          state_nx_s = state_r;
        end
      end
      LOAD: begin
        if (!accept_s) begin
          state_nx_s = LOAD;
        end else if (bus.s_last) begin
          if (bus.s_data == checksum_r) begin
            last_ok_s = 1'b1;
            if ((ZERO_FILL != 32'd0) && !full_s) begin
              state_nx_s = FILL;
            end else begin
              state_nx_s = HOLD;
            end
          end else begin
            state_nx_s = ERROR;
          end
        end else if (full_s) begin
          state_nx_s = ERROR;
        end else begin
          wr_s = 1'b1;
        end
      end
      FILL: begin
        wr_s = 1'b1;
        if (last_s) begin
          state_nx_s = HOLD;
        end else begin
          state_nx_s = FILL;
        end
      end
      HOLD: begin
        if (hold_cnt_r == HOLD_LAST) begin
          state_nx_s = RUN;
        end else begin
          state_nx_s = HOLD;
        end
      end
      default: begin
        state_nx_s = IDLE;
      end
    endcase
  end

  // State, registered outputs, checksum, image length and hold counter.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_r      <= IDLE;
      checksum_r   <= '0;
      words_r      <= '0;
      hold_cnt_r   <= '0;
      s_ready_r    <= 1'b0;
      we_r         <= 1'b0;
      row_r        <= '0;
      col_r        <= '0;
      wdata_r      <= '0;
      cpu_resetn_r <= 1'b0;
      done_r       <= 1'b0;
      error_r      <= 1'b0;
    end else begin
      state_r      <= state_nx_s;
      s_ready_r    <= (state_nx_s == LOAD);
      cpu_resetn_r <= (state_nx_s == RUN);
      done_r       <= (state_nx_s == RUN);
      error_r      <= (state_nx_s == ERROR);
      we_r         <= wr_s;
      if (wr_s) begin
        row_r   <= row_s;
        col_r   <= col_s;
        wdata_r <= (state_r == FILL) ? '0 : bus.s_data;
      end else begin
        row_r   <= row_r;
        col_r   <= col_r;
        wdata_r <= wdata_r;
      end
      // Only data beats feed the checksum; fill writes share wr_s but not LOAD.
      if (addr_clr_s) begin
        checksum_r <= '0;
      end else if (wr_s && (state_r == LOAD)) begin
        checksum_r <= checksum_r ^ bus.s_data;
      end else begin
        checksum_r <= checksum_r;
      end
      if (addr_clr_s) begin
        words_r <= '0;
      end else if (last_ok_s) begin
        words_r <= addr_s;
      end else begin
        words_r <= words_r;
      end
      if (state_r == HOLD) begin
        hold_cnt_r <= hold_cnt_r + HOLD_ONE;
      end else begin
        hold_cnt_r <= '0;
      end
    end
  end

  assign bus.s_ready    = s_ready_r;
  assign bus.sram_we    = we_r;
  assign bus.sram_row   = row_r;
  assign bus.sram_col   = col_r;
  assign bus.sram_wdata = wdata_r;
  assign cpu_resetn     = cpu_resetn_r;
  assign done           = done_r;
  assign error          = error_r;
  assign words_loaded   = words_r;

endmodule
